// File: rtl/store_queue_if.sv
// Memory write port of store_queue: w_en/w_ready request handshake carrying address and data.
interface store_queue_if #(
   parameter int WORD_SIZE    = 8,
   parameter int ADDRESS_SIZE = 4
);
   logic                    w_en;
   logic [WORD_SIZE-1:0]    w_data;
   logic [ADDRESS_SIZE-1:0] w_addr;
   logic                    w_ready;

   modport master (output w_en, w_data, w_addr, input w_ready);
   modport slave  (input w_en, w_data, w_addr, output w_ready);
endinterface

// File: rtl/store_queue.sv
// Captures a word on each rising edge of store into a small FIFO and drains it to consecutive
// memory addresses over the w_en/w_ready handshake. The captured word port is seq_word ("sequence" is reserved).
module store_queue #(
   parameter int WORD_SIZE    = 8,
   parameter int ADDRESS_SIZE = 4,
   parameter int MEMORY_QTY   = 16,
   parameter int QUEUE_DEPTH  = 4,
   parameter int WRAP_MODE    = 0
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  store,
   input  logic [WORD_SIZE-1:0]  seq_word,
   input  logic                  clear,
   store_queue_if.master         mem,
   output logic [ADDRESS_SIZE:0] count,
   output logic                  mem_full,
   output logic                  queue_full,
   output logic                  overflow,
   output logic                  busy
);
   localparam int PTR_W = $clog2(QUEUE_DEPTH);
   localparam logic [ADDRESS_SIZE:0]   FULL_COUNT = (ADDRESS_SIZE+1)'(MEMORY_QTY);
   localparam logic [ADDRESS_SIZE-1:0] LAST_ADDR  = ADDRESS_SIZE'(MEMORY_QTY - 1);
   localparam logic [PTR_W:0]          DEPTH      = (PTR_W+1)'(QUEUE_DEPTH);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   state_t                  state;
   logic                    store_q;
   logic                    clear_pend;
   logic [WORD_SIZE-1:0]    fifo_mem [QUEUE_DEPTH];
   logic [PTR_W-1:0]        rd_idx;
   logic [PTR_W-1:0]        wr_idx;
   logic [PTR_W:0]          occ;
   logic [ADDRESS_SIZE-1:0] wr_ptr;

   logic push_req, do_push, drop_push, done_edge, at_rest, do_flush, do_pop, can_start;

   // NOTE: every signal here is assigned on every path through the block, so no latches can form.
   always_comb begin
      push_req  = store && !store_q;
      do_push   = push_req && !clear && !queue_full;
      drop_push = push_req && !clear && queue_full;
      done_edge = (state == WAIT) && mem.w_ready;
      at_rest   = (state == IDLE) || (state == DONE);
      // A clear arriving mid-handshake is deferred and replaces the pop/increment at completion.
      do_flush  = (at_rest && clear) || (done_edge && (clear || clear_pend));
      do_pop    = done_edge && !(clear || clear_pend);
      can_start = at_rest && !clear && !clear_pend && (occ != '0) && mem.w_ready &&
                  !((WRAP_MODE == 0) && mem_full);
   end

   assign queue_full = (occ == DEPTH);
   assign mem_full   = (count == FULL_COUNT);
   assign busy       = (state != IDLE) || (occ != '0);

   // NOTE: non-blocking assignments so every register samples the pre-edge values of the others.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         store_q    <= 1'b0;
         clear_pend <= 1'b0;
         rd_idx     <= '0;
         wr_idx     <= '0;
         occ        <= '0;
         wr_ptr     <= '0;
         count      <= '0;
         overflow   <= 1'b0;
         mem.w_en   <= 1'b0;
         mem.w_data <= '0;
         mem.w_addr <= '0;
      end else begin
         store_q  <= store;
         overflow <= drop_push;

         if (do_push) wr_idx <= wr_idx + PTR_W'(1);
         if (do_flush) begin
            rd_idx <= wr_idx;
            occ    <= do_push ? (PTR_W+1)'(1) : '0;
         end else begin
            if (do_pop) rd_idx <= rd_idx + PTR_W'(1);
            occ <= occ + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
         end

         if (do_flush) begin
            wr_ptr <= '0;
            count  <= '0;
         end else if (do_pop) begin
            wr_ptr <= (wr_ptr == LAST_ADDR) ? '0 : wr_ptr + ADDRESS_SIZE'(1);
            if (!mem_full) count <= count + (ADDRESS_SIZE+1)'(1);
         end

         // DONE re-arms directly so back-to-back writes leave w_en low for a single cycle.
         case (state)
            IDLE, DONE: begin
               if (can_start) begin
                  state      <= ISSUE;
                  mem.w_en   <= 1'b1;
                  mem.w_data <= fifo_mem[rd_idx];
                  mem.w_addr <= wr_ptr;
               end else begin
                  state <= IDLE;
               end
            end
            ISSUE: begin
               if (clear)         clear_pend <= 1'b1;
               if (!mem.w_ready)  state      <= WAIT;
            end
            WAIT: begin
               if (done_edge) begin
                  state      <= DONE;
                  mem.w_en   <= 1'b0;
                  clear_pend <= 1'b0;
               end else if (clear) begin
                  clear_pend <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // NOTE: FIFO storage is not reset; occupancy alone decides which entries are valid.
   always_ff @(posedge clock) begin
      if (do_push) fifo_mem[wr_idx] <= seq_word;
   end
endmodule

// File: tb/tb_store_queue.sv
// Directed bench for store_queue: stop-mode and wrap-mode instances, each driven by a delayed-ready memory model.
module tb_store_queue;
   logic       clock;
   logic       reset;
   logic       store;
   logic       clear;
   logic [7:0] seq_word;

   store_queue_if #(.WORD_SIZE(8), .ADDRESS_SIZE(4)) bus0 ();
   store_queue_if #(.WORD_SIZE(8), .ADDRESS_SIZE(4)) bus1 ();

   logic [4:0] count0, count1;
   logic       mem_full0, mem_full1, queue_full0, queue_full1;
   logic       overflow0, overflow1, busy0, busy1;

   store_queue #(.WORD_SIZE(8), .ADDRESS_SIZE(4), .MEMORY_QTY(16), .QUEUE_DEPTH(4), .WRAP_MODE(0)) dut (
      .clock(clock), .reset(reset), .store(store), .seq_word(seq_word), .clear(clear), .mem(bus0),
      .count(count0), .mem_full(mem_full0), .queue_full(queue_full0), .overflow(overflow0), .busy(busy0));

   store_queue #(.WORD_SIZE(8), .ADDRESS_SIZE(4), .MEMORY_QTY(16), .QUEUE_DEPTH(4), .WRAP_MODE(1)) dut_wrap (
      .clock(clock), .reset(reset), .store(store), .seq_word(seq_word), .clear(clear), .mem(bus1),
      .count(count1), .mem_full(mem_full1), .queue_full(queue_full1), .overflow(overflow1), .busy(busy1));

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct packed {
      logic [3:0] addr;
      logic [7:0] data;
   } wr_t;

   // Memory model: accepts a request while ready, then holds ready low for mem_delay sampled edges.
   int  mem_delay;
   bit  mem_hold;
   int  rem0, rem1;
   bit  acc0, acc1;
   wr_t log0[$];
   wr_t log1[$];

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         bus0.w_ready <= 1'b1; rem0 <= 0; acc0 <= 1'b0; log0.delete();
      end else if (mem_hold) begin
         bus0.w_ready <= 1'b0;
      end else if (rem0 > 0) begin
         rem0 <= rem0 - 1; bus0.w_ready <= (rem0 == 1);
      end else if (bus0.w_en && bus0.w_ready && !acc0) begin
         log0.push_back(wr_t'({bus0.w_addr, bus0.w_data}));
         rem0 <= mem_delay; bus0.w_ready <= 1'b0; acc0 <= 1'b1;
      end else begin
         bus0.w_ready <= 1'b1;
         if (!bus0.w_en) acc0 <= 1'b0;
      end
   end

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         bus1.w_ready <= 1'b1; rem1 <= 0; acc1 <= 1'b0; log1.delete();
      end else if (mem_hold) begin
         bus1.w_ready <= 1'b0;
      end else if (rem1 > 0) begin
         rem1 <= rem1 - 1; bus1.w_ready <= (rem1 == 1);
      end else if (bus1.w_en && bus1.w_ready && !acc1) begin
         log1.push_back(wr_t'({bus1.w_addr, bus1.w_data}));
         rem1 <= mem_delay; bus1.w_ready <= 1'b0; acc1 <= 1'b1;
      end else begin
         bus1.w_ready <= 1'b1;
         if (!bus1.w_en) acc1 <= 1'b0;
      end
   end

   // Monitor on the stop-mode instance: overflow cycles and w_en low-gaps between writes.
   int ovf_cnt;
   int low_run;
   bit seen_write;
   bit prev_en;
   int gaps[$];

   always @(negedge clock) begin
      if (reset) begin
         ovf_cnt <= 0; low_run <= 0; seen_write <= 1'b0; prev_en <= 1'b0; gaps.delete();
      end else begin
         if (overflow0) ovf_cnt <= ovf_cnt + 1;
         if (bus0.w_en && !prev_en && seen_write) gaps.push_back(low_run);
         low_run    <= bus0.w_en ? 0 : low_run + 1;
         seen_write <= seen_write || bus0.w_en;
         prev_en    <= bus0.w_en;
      end
   end

   int checks;
   int errors;

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got %0h, want %0h", name, actual, expected);
      end
   endtask

   task automatic do_reset();
      store = 1'b0;
      clear = 1'b0;
      reset = 1'b1;
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
   endtask

   task automatic press(input logic [7:0] v, input int low_cycles);
      seq_word = v;
      store    = 1'b1;
      @(posedge clock); #1;
      store = 1'b0;
      repeat (low_cycles) begin
         @(posedge clock); #1;
      end
   endtask

   task automatic wait_idle(input int which, input string name);
      int n;
      n = 0;
      while (((which == 0) ? busy0 : busy1) && n < 500) begin
         @(posedge clock); #1;
         n++;
      end
      check({name, ".idle"}, (which == 0) ? busy0 : busy1, 1'b0);
   endtask

   typedef struct {
      logic       store;
      logic [7:0] seq;
      logic       w_en;
      logic [3:0] addr;
      logic [7:0] data;
      logic [4:0] count;
      logic       busy;
   } vec_t;

   vec_t vecs[7];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded its time limit");
      $fatal(1);
   end

   initial begin
      bit en_seen;
      checks    = 0;
      errors    = 0;
      mem_delay = 2;
      mem_hold  = 1'b0;
      seq_word  = 8'h00;
      reset     = 1'b1;

      // Single store with a 2-edge memory delay, one record per clock edge.
      vecs[0] = '{1'b1, 8'h5A, 1'b0, 4'h0, 8'h00, 5'd0, 1'b1};
      vecs[1] = '{1'b0, 8'hFF, 1'b1, 4'h0, 8'h5A, 5'd0, 1'b1};
      vecs[2] = '{1'b0, 8'hFF, 1'b1, 4'h0, 8'h5A, 5'd0, 1'b1};
      vecs[3] = '{1'b0, 8'hFF, 1'b1, 4'h0, 8'h5A, 5'd0, 1'b1};
      vecs[4] = '{1'b0, 8'hFF, 1'b1, 4'h0, 8'h5A, 5'd0, 1'b1};
      vecs[5] = '{1'b0, 8'hFF, 1'b0, 4'h0, 8'h00, 5'd1, 1'b1};
      vecs[6] = '{1'b0, 8'hFF, 1'b0, 4'h0, 8'h00, 5'd1, 1'b0};

      do_reset();
      check("reset.w_en", bus0.w_en, 1'b0);
      check("reset.count", count0, 5'd0);
      check("reset.busy", busy0, 1'b0);
      check("reset.overflow", overflow0, 1'b0);
      check("reset.queue_full", queue_full0, 1'b0);
      check("reset.mem_full", mem_full0, 1'b0);

      for (int i = 0; i < 7; i++) begin
         store    = vecs[i].store;
         seq_word = vecs[i].seq;
         @(posedge clock); #1;
         check($sformatf("single[%0d].w_en", i), bus0.w_en, vecs[i].w_en);
         if (vecs[i].w_en) begin
            check($sformatf("single[%0d].w_addr", i), bus0.w_addr, vecs[i].addr);
            check($sformatf("single[%0d].w_data", i), bus0.w_data, vecs[i].data);
         end
         check($sformatf("single[%0d].count", i), count0, vecs[i].count);
         check($sformatf("single[%0d].busy", i), busy0, vecs[i].busy);
      end

      // Burst of 5 stores two cycles apart while each write occupies 4 cycles.
      do_reset();
      for (int i = 0; i < 5; i++) press(8'hA0 + 8'(i), 1);
      wait_idle(0, "burst");
      check("burst.overflows", ovf_cnt, 0);
      check("burst.writes", log0.size(), 5);
      for (int i = 0; i < 5; i++) begin
         check($sformatf("burst[%0d].addr", i), log0[i].addr, i);
         check($sformatf("burst[%0d].data", i), log0[i].data, 8'hA0 + 8'(i));
      end
      check("burst.gap_count", gaps.size(), 4);
      for (int i = 0; i < 4; i++) check($sformatf("burst.gap[%0d]", i), gaps[i], 1);
      check("burst.count", count0, 5'd5);

      // Memory never ready: four stores fill the FIFO, each further store is dropped.
      mem_hold = 1'b1;
      do_reset();
      for (int i = 0; i < 4; i++) press(8'h10 + 8'(i), 1);
      check("ovf.queue_full", queue_full0, 1'b1);
      check("ovf.none_yet", ovf_cnt, 0);
      press(8'h14, 1);
      check("ovf.first_drop", ovf_cnt, 1);
      press(8'h15, 1);
      check("ovf.second_drop", ovf_cnt, 2);
      check("ovf.pulse_ended", overflow0, 1'b0);
      mem_hold = 1'b0;
      wait_idle(0, "ovf");
      check("ovf.writes", log0.size(), 4);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("ovf[%0d].addr", i), log0[i].addr, i);
         check($sformatf("ovf[%0d].data", i), log0[i].data, 8'h10 + 8'(i));
      end

      // 17 stores: stop mode halts at 16 writes, wrap mode rolls the address over.
      mem_delay = 1;
      do_reset();
      for (int i = 0; i < 17; i++) press(8'h30 + 8'(i), 5);
      repeat (10) begin @(posedge clock); #1; end
      check("stop.count", count0, 5'd16);
      check("stop.mem_full", mem_full0, 1'b1);
      check("stop.held_in_fifo", busy0, 1'b1);
      check("stop.writes", log0.size(), 16);
      check("stop.last.addr", log0[15].addr, 4'hF);
      check("stop.last.data", log0[15].data, 8'h3F);
      en_seen = 1'b0;
      repeat (8) begin
         @(posedge clock); #1;
         if (bus0.w_en) en_seen = 1'b1;
      end
      check("stop.w_en_low", en_seen, 1'b0);
      check("wrap.writes17", log1.size(), 17);
      check("wrap[16].addr", log1[16].addr, 4'h0);
      check("wrap[16].data", log1[16].data, 8'h40);
      press(8'h41, 5);
      wait_idle(1, "wrap");
      check("wrap.writes18", log1.size(), 18);
      check("wrap[17].addr", log1[17].addr, 4'h1);
      check("wrap[17].data", log1[17].data, 8'h41);
      check("wrap.count", count1, 5'd16);
      check("wrap.mem_full", mem_full1, 1'b1);
      check("stop.still16", log0.size(), 16);

      // Clear while in WAIT with two entries queued behind the in-flight write.
      mem_delay = 5;
      do_reset();
      press(8'hB0, 1);
      press(8'hB1, 1);
      press(8'hB2, 1);
      check("clr.in_flight", bus0.w_en, 1'b1);
      check("clr.mem_busy", bus0.w_ready, 1'b0);
      clear = 1'b1;
      @(posedge clock); #1;
      clear = 1'b0;
      wait_idle(0, "clr");
      check("clr.writes", log0.size(), 1);
      check("clr.addr", log0[0].addr, 4'h0);
      check("clr.data", log0[0].data, 8'hB0);
      check("clr.count", count0, 5'd0);
      check("clr.queue_full", queue_full0, 1'b0);
      press(8'hC3, 1);
      wait_idle(0, "clr_next");
      check("clr_next.writes", log0.size(), 2);
      check("clr_next.addr", log0[1].addr, 4'h0);
      check("clr_next.data", log0[1].data, 8'hC3);
      check("clr_next.count", count0, 5'd1);

      // Reset between clock edges must drop w_en at once.
      do_reset();
      press(8'hD0, 1);
      check("arst.w_en_before", bus0.w_en, 1'b1);
      #2 reset = 1'b1;
      #1;
      check("arst.w_en_after", bus0.w_en, 1'b0);
      check("arst.busy_after", busy0, 1'b0);
      @(posedge clock); #1;
      reset = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
